// File: rtl/pacman_ctrl_if.sv
// Button inputs and game outputs between the Pac-Man controller and its surroundings.
// The master drives buttons and observes game state; the controller is the slave.
interface pacman_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [3:0] state;
    logic [2:0] direction;
    logic [3:0] cheese;
    logic       eaten;
    logic [3:0] score;

    modport master (
        output btn_up, btn_down, btn_left, btn_right,
        input  state, direction, cheese, eaten, score
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right,
        output state, direction, cheese, eaten, score
    );
endinterface

// File: rtl/pacman_ctrl.sv
// Pac-Man game controller: steps a position on a 4x2 grid at a fixed rate,
// steered by button edges, and tracks a randomly placed cheese plus a score.
module pacman_ctrl #(
    parameter int         STEP_CYCLES = 50_000_000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    pacman_ctrl_if.slave  bus
);
    localparam int            CW   = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Cell codes skip 2: idx 0,1 map directly, idx 2..7 map to 3..8.
    function automatic logic [3:0] idx2code(input logic [2:0] idx);
        return (idx < 3'd2) ? {1'b0, idx} : ({1'b0, idx} + 4'd1);
    endfunction

    logic [3:0]    btn_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pos_q, pos_d;
    logic [2:0]    cheese_q, cheese_d;
    dir_t          dir_q, dir_d;
    logic [3:0]    score_q, score_d;
    logic          eaten_q;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [3:0]    state_code_q;
    logic [3:0]    cheese_code_q;

    logic [3:0] btn_now;
    logic [3:0] rise;
    logic       press;
    dir_t       new_dir;
    dir_t       head;
    logic       step;
    logic       blocked;
    logic [2:0] mv;
    logic       eat;
    logic [2:0] cand;

    always_comb begin
        btn_now = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
        rise    = btn_now & ~btn_q;
        press   = |rise;
        if (rise[3])      new_dir = DIR_UP;
        else if (rise[2]) new_dir = DIR_DOWN;
        else if (rise[1]) new_dir = DIR_LEFT;
        else              new_dir = DIR_RIGHT;

        dir_d = press ? new_dir : dir_q;
        head  = dir_d;
        step  = (cnt_q == LAST);
        cnt_d = step ? '0 : cnt_q + 1'b1;

        blocked = 1'b0;
        mv      = pos_q;
        case (head)
            DIR_RIGHT: mv = {pos_q[2], pos_q[1:0] + 2'd1};
            DIR_LEFT:  mv = {pos_q[2], pos_q[1:0] - 2'd1};
            DIR_DOWN: begin
                blocked = pos_q[2];
                mv      = {1'b1, pos_q[1:0]};
            end
            default: begin
                blocked = ~pos_q[2];
                mv      = {1'b0, pos_q[1:0]};
            end
        endcase

        pos_d = (step && !blocked) ? mv : pos_q;
        eat   = step && !blocked && (mv == cheese_q);

        // Bump the candidate off Pac-Man's landing cell so the two never coincide.
        cand     = (lfsr_q[2:0] == mv) ? (lfsr_q[2:0] + 3'd1) : lfsr_q[2:0];
        cheese_d = eat ? cand : cheese_q;
        score_d  = (eat && score_q != 4'd15) ? score_q + 4'd1 : score_q;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q         <= '0;
            cnt_q         <= '0;
            pos_q         <= 3'd0;
            cheese_q      <= 3'd7;
            dir_q         <= DIR_RIGHT;
            score_q       <= '0;
            eaten_q       <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            state_code_q  <= 4'd0;
            cheese_code_q <= 4'd8;
        end else begin
            btn_q         <= btn_now;
            cnt_q         <= cnt_d;
            pos_q         <= pos_d;
            cheese_q      <= cheese_d;
            dir_q         <= dir_d;
            score_q       <= score_d;
            eaten_q       <= eat;
            lfsr_q        <= lfsr_d;
            state_code_q  <= idx2code(pos_d);
            cheese_code_q <= idx2code(cheese_d);
        end
    end

    assign bus.state     = state_code_q;
    assign bus.direction = {1'b0, dir_q};
    assign bus.cheese    = cheese_code_q;
    assign bus.eaten     = eaten_q;
    assign bus.score     = score_q;
endmodule

// File: tb/tb_pacman_ctrl.sv
// Directed bench for pacman_ctrl with a 4-cycle step interval.
module tb_pacman_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   pos_m = 0;
    int   score_m = 0;

    pacman_ctrl_if bus ();

    pacman_ctrl #(.STEP_CYCLES(4), .LFSR_SEED(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    function automatic int code_of(input int idx);
        int tbl [8] = '{0, 1, 3, 4, 5, 6, 7, 8};
        return tbl[idx];
    endfunction

    function automatic int idx_of(input int code);
        return (code < 2) ? code : code - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        tick();
        rst = 1'b0;
        pos_m = 0;
        score_m = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        tick();
        tick();
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        checks++; if (bus.direction !== 3'd3) begin errors++; $display("FAIL reset_dir: got %0d want 3", bus.direction); end
        checks++; if (bus.cheese !== 4'd8) begin errors++; $display("FAIL reset_cheese: got %0d want 8", bus.cheese); end
        checks++; if (bus.score !== 4'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", bus.score); end
        checks++; if (bus.eaten !== 1'b0) begin errors++; $display("FAIL reset_eaten: got %0d want 0", bus.eaten); end
        for (int i = 0; i < 10; i++) begin
            bus.btn_left = i[0];
            tick();
            checks++;
            if (bus.state !== 4'd0 || bus.direction !== 3'd3) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: state %0d dir %0d want 0 3", i, bus.state, bus.direction);
            end
        end
        bus.btn_left = 0;
        tick();
        rst = 1'b0;
        pos_m = 0;
        score_m = 0;
    endtask

    task automatic test_free_run();
        int exp;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp = (i < 4) ? 0 : (i < 8) ? 1 : (i < 12) ? 3 : (i < 16) ? 4 : 0;
            checks++;
            if (bus.state !== 4'(exp) || bus.direction !== 3'd3) begin
                errors++;
                $display("FAIL free_run edge %0d: state %0d dir %0d want %0d 3", i, bus.state, bus.direction, exp);
            end
        end
        pos_m = 0;
    endtask

    task automatic test_blocked_vertical();
        repeat (4) tick();
        checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL vert_setup: state %0d want 1", bus.state); end
        bus.btn_up = 1;
        tick();
        bus.btn_up = 0;
        checks++; if (bus.direction !== 3'd0) begin errors++; $display("FAIL up_dir: got %0d want 0", bus.direction); end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (bus.state !== 4'd1 || bus.direction !== 3'd0 || bus.eaten !== 1'b0) begin
                errors++;
                $display("FAIL up_blocked cycle %0d: state %0d dir %0d eaten %0d want 1 0 0", i, bus.state, bus.direction, bus.eaten);
            end
        end
        bus.btn_down = 1;
        tick();
        bus.btn_down = 0;
        checks++; if (bus.direction !== 3'd1 || bus.state !== 4'd1) begin errors++; $display("FAIL down_dir: dir %0d state %0d want 1 1", bus.direction, bus.state); end
        tick();
        tick();
        checks++; if (bus.state !== 4'd6) begin errors++; $display("FAIL down_step: state %0d want 6", bus.state); end
        pos_m = 5;
    endtask

    task automatic test_coincident();
        do_reset();
        repeat (3) tick();
        checks++; if (bus.state !== 4'd0 || bus.direction !== 3'd3) begin errors++; $display("FAIL coinc_pre: state %0d dir %0d want 0 3", bus.state, bus.direction); end
        bus.btn_left = 1;
        bus.btn_right = 1;
        tick();
        bus.btn_left = 0;
        bus.btn_right = 0;
        checks++; if (bus.direction !== 3'd2) begin errors++; $display("FAIL coinc_dir: got %0d want 2", bus.direction); end
        checks++; if (bus.state !== 4'd4) begin errors++; $display("FAIL coinc_state: got %0d want 4", bus.state); end
        pos_m = 3;
    endtask

    // Steers toward the cheese one step at a time; entry and exit at counter 0.
    task automatic run_eats(input int n);
        int got = 0;
        int steps = 0;
        int cidx, nxt, hd;
        bit exp_eat;
        while (got < n && steps < 100) begin
            steps++;
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++;
                if (bus.eaten !== 1'b0) begin errors++; $display("FAIL eaten_idle: got %0d want 0", bus.eaten); end
            end
            cidx = idx_of(int'(bus.cheese));
            if ((pos_m / 4) != (cidx / 4)) begin
                hd  = (pos_m < 4) ? 1 : 0;
                nxt = (pos_m < 4) ? pos_m + 4 : pos_m - 4;
                if (hd == 1) bus.btn_down = 1; else bus.btn_up = 1;
            end else begin
                hd  = 3;
                nxt = (pos_m & 4) | ((pos_m + 1) & 3);
                bus.btn_right = 1;
            end
            exp_eat = (nxt == cidx);
            tick();
            bus.btn_up = 0; bus.btn_down = 0; bus.btn_right = 0;
            pos_m = nxt;
            if (exp_eat) begin
                got++;
                if (score_m < 15) score_m++;
            end
            checks++;
            if (bus.state !== 4'(code_of(pos_m)) || bus.direction !== 3'(hd)) begin
                errors++;
                $display("FAIL eat_move: state %0d dir %0d want %0d %0d", bus.state, bus.direction, code_of(pos_m), hd);
            end
            checks++;
            if (bus.eaten !== exp_eat || bus.score !== 4'(score_m)) begin
                errors++;
                $display("FAIL eat_pulse: eaten %0d score %0d want %0d %0d", bus.eaten, bus.score, exp_eat, score_m);
            end
            if (exp_eat) begin
                checks++;
                if (bus.cheese === bus.state || bus.cheese === 4'd2 || bus.cheese > 4'd8) begin
                    errors++;
                    $display("FAIL cheese_reloc: cheese %0d state %0d want legal and distinct", bus.cheese, bus.state);
                end
            end
        end
        checks++;
        if (got < n) begin errors++; $display("FAIL eat_budget: eats %0d want %0d", got, n); end
    endtask

    task automatic test_eat();
        run_eats(1);
        checks++; if (bus.state !== 4'd8 || bus.eaten !== 1'b1 || bus.score !== 4'd1) begin errors++; $display("FAIL first_eat: state %0d eaten %0d score %0d want 8 1 1", bus.state, bus.eaten, bus.score); end
        checks++; if (bus.cheese === 4'd8) begin errors++; $display("FAIL first_cheese: cheese %0d want not 8", bus.cheese); end
        tick();
        checks++; if (bus.eaten !== 1'b0) begin errors++; $display("FAIL eaten_one_cycle: got %0d want 0", bus.eaten); end
        tick();
        tick();
        tick();
        run_eats(16);
        checks++; if (bus.score !== 4'd15) begin errors++; $display("FAIL score_saturate: got %0d want 15", bus.score); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_eats(3);
        checks++; if (bus.score !== 4'd3) begin errors++; $display("FAIL mid_score: got %0d want 3", bus.score); end
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pos_m = 0;
        score_m = 0;
        checks++;
        if (bus.state !== 4'd0 || bus.direction !== 3'd3 || bus.cheese !== 4'd8 || bus.score !== 4'd0 || bus.eaten !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: state %0d dir %0d cheese %0d score %0d eaten %0d want 0 3 8 0 0",
                     bus.state, bus.direction, bus.cheese, bus.score, bus.eaten);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.state !== ((i == 4) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL mid_first_step cycle %0d: state %0d want %0d", i, bus.state, (i == 4) ? 1 : 0);
            end
        end
    endtask

    initial begin
        bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        test_reset();
        test_free_run();
        test_blocked_vertical();
        test_coincident();
        test_eat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
